// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, early j/jal resolution, and IF/ID pipeline register.
// Next-PC priority is reset > redirect > stall > jump > pc+4.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc4;
    logic        w_is_jump;
    logic [31:0] w_jump_target;
    logic [31:0] w_pc_next;

    assign w_pc4         = r_pc + 32'd4;
    assign w_is_jump     = (imem_rdata[31:26] == 6'b000010) || (imem_rdata[31:26] == 6'b000011);
    assign w_jump_target = {w_pc4[31:28], imem_rdata[25:0], 2'b00};

    always_comb begin
        w_pc_next = w_pc4;
        if (redirect) begin
            // Redirect targets are forced word-aligned on load.
            w_pc_next = {redirect_pc[31:2], 2'b00};
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (w_is_jump) begin
            w_pc_next = w_jump_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_ifid_instr  <= NOP_WORD;
            r_ifid_pc4    <= '0;
            r_ifid_valid  <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (redirect) begin
                r_ifid_instr <= NOP_WORD;
                r_ifid_pc4   <= '0;
                r_ifid_valid <= 1'b0;
            end else if (!stall) begin
                r_ifid_instr  <= imem_rdata;
                r_ifid_pc4    <= w_pc4;
                r_ifid_valid  <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign ifid_instr  = r_ifid_instr;
    assign ifid_pc4    = r_ifid_pc4;
    assign ifid_valid  = r_ifid_valid;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table of per-edge inputs and expected
// post-edge state, followed by a hand-written misaligned redirect / wrap sequence.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'hFFFF0000;
    localparam logic [31:0] I   = 32'h20080001;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    int unsigned checks;
    int unsigned failures;

    if_stage #(
        .RESET_PC(32'h00000000),
        .NOP_WORD(NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc,
                       input logic [31:0] rdata, input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.rdata = rdata;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%08h expected=%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic rdr,
                         input logic [31:0] rpc, input logic [31:0] rdata);
        reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc; imem_rdata = rdata;
    endtask

    task automatic check_state(input int idx, input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_cnt);
        check("imem_addr",   idx, imem_addr,   e_pc);
        check("ifid_instr",  idx, ifid_instr,  e_instr);
        check("ifid_pc4",    idx, ifid_pc4,    e_pc4);
        check("ifid_valid",  idx, {31'b0, ifid_valid}, {31'b0, e_valid});
        check("fetch_count", idx, fetch_count, e_cnt);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, I);

        //   rst   stl   rdr   redirect_pc    rdata          pc             instr          pc4            v     cnt
        add(1'b1, 1'b0, 1'b0, 32'h00000000, I,             32'h00000000, NOP,           32'h00000000, 1'b0, 32'd0);
        add(1'b1, 1'b1, 1'b1, 32'h00000040, I,             32'h00000000, NOP,           32'h00000000, 1'b0, 32'd0);
        add(1'b0, 1'b0, 1'b0, 32'h00000000, I,             32'h00000004, I,             32'h00000004, 1'b1, 32'd1);
        add(1'b0, 1'b0, 1'b0, 32'h00000000, I,             32'h00000008, I,             32'h00000008, 1'b1, 32'd2);
        add(1'b0, 1'b1, 1'b0, 32'h00000000, 32'hDEADBEEF,  32'h00000008, I,             32'h00000008, 1'b1, 32'd2);
        add(1'b0, 1'b1, 1'b0, 32'h00000000, 32'h12345678,  32'h00000008, I,             32'h00000008, 1'b1, 32'd2);
        add(1'b0, 1'b0, 1'b0, 32'h00000000, I,             32'h0000000C, I,             32'h0000000C, 1'b1, 32'd3);
        add(1'b0, 1'b1, 1'b1, 32'h00000043, I,             32'h00000040, NOP,           32'h00000000, 1'b0, 32'd3);
        add(1'b0, 1'b0, 1'b0, 32'h00000000, 32'h11111111,  32'h00000044, 32'h11111111,  32'h00000044, 1'b1, 32'd4);
        add(1'b0, 1'b0, 1'b1, 32'h10000010, I,             32'h10000010, NOP,           32'h00000000, 1'b0, 32'd4);
        add(1'b0, 1'b0, 1'b0, 32'h00000000, 32'h08000100,  32'h10000400, 32'h08000100,  32'h10000014, 1'b1, 32'd5);
        add(1'b0, 1'b0, 1'b0, 32'h00000000, 32'h0C000004,  32'h10000010, 32'h0C000004,  32'h10000404, 1'b1, 32'd6);
        add(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, I,             32'hFFFFFFFC, NOP,           32'h00000000, 1'b0, 32'd6);
        add(1'b0, 1'b0, 1'b0, 32'h00000000, I,             32'h00000000, I,             32'h00000000, 1'b1, 32'd7);
        add(1'b0, 1'b1, 1'b0, 32'h00000000, 32'h08000100,  32'h00000000, I,             32'h00000000, 1'b1, 32'd7);
        add(1'b1, 1'b1, 1'b1, 32'h00000040, 32'h08000100,  32'h00000000, NOP,           32'h00000000, 1'b0, 32'd0);
        add(1'b0, 1'b0, 1'b0, 32'h00000000, I,             32'h00000004, I,             32'h00000004, 1'b1, 32'd1);

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].stl, vecs[k].rdr, vecs[k].rpc, vecs[k].rdata);
            @(posedge clk);
            #1;
            check_state(k, vecs[k].e_pc, vecs[k].e_instr, vecs[k].e_pc4, vecs[k].e_valid, vecs[k].e_cnt);
        end

        // Misaligned redirect to the top word, then free-run across the wrap.
        drive(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, I);
        @(posedge clk); #1;
        check_state(100, 32'hFFFFFFFC, NOP, 32'h00000000, 1'b0, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'hA5A5A5A5);
        #1;
        check("imem_addr_comb", 101, imem_addr, 32'hFFFFFFFC);
        @(posedge clk); #1;
        check_state(102, 32'h00000000, 32'hA5A5A5A5, 32'h00000000, 1'b1, 32'd2);
        drive(1'b0, 1'b0, 1'b0, 32'h0, I);
        @(posedge clk); #1;
        check_state(103, 32'h00000004, I, 32'h00000004, 1'b1, 32'd3);
        // Redirect wins over a jump opcode on the same edge.
        drive(1'b0, 1'b0, 1'b1, 32'h00000200, 32'h08000100);
        @(posedge clk); #1;
        check_state(104, 32'h00000200, NOP, 32'h00000000, 1'b0, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
